// File: rtl/ctrl_pkg.sv
// Shared encodings for the CR16-subset control path: states, opcode/ext fields,
// condition codes, PC/writeback select values and PSR bit positions.
package ctrl_pkg;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StLatch = 2'd1,
    StExec  = 2'd2,
    StWb    = 2'd3
  } state_e;

  // Primary opcodes, instr[15:12]
  localparam logic [3:0] OpRtype = 4'b0000;
  localparam logic [3:0] OpAndi  = 4'b0001;
  localparam logic [3:0] OpOri   = 4'b0010;
  localparam logic [3:0] OpXori  = 4'b0011;
  localparam logic [3:0] OpMem   = 4'b0100;
  localparam logic [3:0] OpAddi  = 4'b0101;
  localparam logic [3:0] OpShift = 4'b1000;
  localparam logic [3:0] OpSubi  = 4'b1001;
  localparam logic [3:0] OpCmpi  = 4'b1011;
  localparam logic [3:0] OpBcond = 4'b1100;
  localparam logic [3:0] OpMovi  = 4'b1101;
  localparam logic [3:0] OpLui   = 4'b1111;

  // Extended opcodes, instr[7:4]
  localparam logic [3:0] ExtAdd   = 4'b0101;
  localparam logic [3:0] ExtAddu  = 4'b0110;
  localparam logic [3:0] ExtAddc  = 4'b0111;
  localparam logic [3:0] ExtSub   = 4'b1001;
  localparam logic [3:0] ExtCmp   = 4'b1011;
  localparam logic [3:0] ExtLoad  = 4'b0000;
  localparam logic [3:0] ExtStor  = 4'b0100;
  localparam logic [3:0] ExtJal   = 4'b1000;
  localparam logic [3:0] ExtJcond = 4'b1100;

  // Condition codes, instr[11:8]
  localparam logic [3:0] CondEq = 4'b0000;
  localparam logic [3:0] CondNe = 4'b0001;
  localparam logic [3:0] CondCs = 4'b0010;
  localparam logic [3:0] CondCc = 4'b0011;
  localparam logic [3:0] CondHi = 4'b0100;
  localparam logic [3:0] CondLs = 4'b0101;
  localparam logic [3:0] CondGt = 4'b0110;
  localparam logic [3:0] CondLe = 4'b0111;
  localparam logic [3:0] CondFs = 4'b1000;
  localparam logic [3:0] CondFc = 4'b1001;
  localparam logic [3:0] CondLo = 4'b1010;
  localparam logic [3:0] CondHs = 4'b1011;
  localparam logic [3:0] CondLt = 4'b1100;
  localparam logic [3:0] CondGe = 4'b1101;
  localparam logic [3:0] CondUc = 4'b1110;

  localparam logic [1:0] PcSelInc  = 2'b00;
  localparam logic [1:0] PcSelDisp = 2'b01;
  localparam logic [1:0] PcSelReg  = 2'b10;

  localparam logic [1:0] WbSelAlu  = 2'b00;
  localparam logic [1:0] WbSelMem  = 2'b01;
  localparam logic [1:0] WbSelLink = 2'b10;

  localparam int unsigned PsrC = 0;
  localparam int unsigned PsrL = 2;
  localparam int unsigned PsrF = 5;
  localparam int unsigned PsrZ = 6;
  localparam int unsigned PsrN = 7;

  // Immediate-form ALU opcodes that share the R-type execute behaviour
  function automatic logic is_imm_alu(logic [3:0] op);
    return (op == OpAndi) || (op == OpOri) || (op == OpXori) || (op == OpAddi) ||
           (op == OpSubi) || (op == OpCmpi) || (op == OpMovi) || (op == OpLui);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch/jump condition evaluator over the PSR flags.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0]  cond,
  input  logic [15:0] psr,
  output logic        take
);

  logic w_c, w_l, w_f, w_z, w_n;
  logic w_unused_psr;

  assign w_c = psr[PsrC];
  assign w_l = psr[PsrL];
  assign w_f = psr[PsrF];
  assign w_z = psr[PsrZ];
  assign w_n = psr[PsrN];
  assign w_unused_psr = ^{psr[15:8], psr[4:3], psr[1]};

  always_comb begin
    take = 1'b0;
    case (cond)
      CondEq:  take = w_z;
      CondNe:  take = ~w_z;
      CondCs:  take = w_c;
      CondCc:  take = ~w_c;
      CondHi:  take = w_l;
      CondLs:  take = ~w_l;
      CondGt:  take = w_n;
      CondLe:  take = ~w_n;
      CondFs:  take = w_f;
      CondFc:  take = ~w_f;
      CondLo:  take = ~w_l & ~w_z;
      CondHs:  take = w_l | w_z;
      CondLt:  take = ~w_n & ~w_z;
      CondGe:  take = w_n | w_z;
      CondUc:  take = 1'b1;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle FETCH/LATCH/EXEC/WB sequencer for the CR16-subset datapath.
// Define CTRL_MEM_WAIT_EN to add the mem_ready handshake on fetch, load and store.
module ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic [15:0] psr,
`ifdef CTRL_MEM_WAIT_EN
  input  logic        mem_ready,
`endif
  output logic        pc_en,
  output logic        instr_en,
  output logic        cmp_f_en,
  output logic        of_f_en,
  output logic        z_f_en,
  output logic        rf_wr_en,
  output logic        mem_wr_en,
  output logic        addr_sel,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic        imm_sel,
  output logic [1:0]  state
);

  state_e     r_state;
  state_e     w_state_next;
  logic [3:0] w_op;
  logic [3:0] w_ext;
  logic [3:0] w_cond;
  logic       w_take;
  logic       w_mem_ready;
  logic       w_is_cmp;
  logic       w_is_add;
  logic       w_unused_instr;

`ifdef CTRL_MEM_WAIT_EN
  assign w_mem_ready = mem_ready;
`else
  assign w_mem_ready = 1'b1;
`endif

  assign w_op   = instr[15:12];
  assign w_cond = instr[11:8];
  assign w_ext  = instr[7:4];
  assign w_unused_instr = ^instr[3:0];

  assign w_is_cmp = ((w_op == OpRtype) && (w_ext == ExtCmp)) || (w_op == OpCmpi);
  assign w_is_add = ((w_op == OpRtype) &&
                     ((w_ext == ExtAdd) || (w_ext == ExtAddu) ||
                      (w_ext == ExtAddc) || (w_ext == ExtSub))) ||
                    (w_op == OpAddi) || (w_op == OpSubi);

  cond_eval u_cond_eval (
    .cond (w_cond),
    .psr  (psr),
    .take (w_take)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign state = r_state;

  always_comb begin
    w_state_next = r_state;
    pc_en        = 1'b0;
    instr_en     = 1'b0;
    cmp_f_en     = 1'b0;
    of_f_en      = 1'b0;
    z_f_en       = 1'b0;
    rf_wr_en     = 1'b0;
    mem_wr_en    = 1'b0;
    addr_sel     = 1'b0;
    pc_sel       = PcSelInc;
    wb_sel       = WbSelAlu;
    imm_sel      = 1'b0;

    case (r_state)
      StFetch: begin
        if (w_mem_ready) w_state_next = StLatch;
      end

      StLatch: begin
        instr_en     = 1'b1;
        w_state_next = StExec;
      end

      StExec: begin
        w_state_next = StFetch;
        if ((w_op == OpRtype) || is_imm_alu(w_op)) begin
          pc_en   = 1'b1;
          imm_sel = (w_op != OpRtype);
          of_f_en = w_is_add;
          // Compares only update flags, never the destination register
          if (w_is_cmp) begin
            cmp_f_en = 1'b1;
            z_f_en   = 1'b1;
          end else begin
            rf_wr_en = 1'b1;
          end
        end else begin
          case (w_op)
            OpShift: begin
              rf_wr_en = 1'b1;
              pc_en    = 1'b1;
            end
            OpBcond: begin
              pc_en  = 1'b1;
              pc_sel = w_take ? PcSelDisp : PcSelInc;
            end
            OpMem: begin
              case (w_ext)
                ExtLoad: begin
                  addr_sel     = 1'b1;
                  w_state_next = w_mem_ready ? StWb : StExec;
                end
                ExtStor: begin
                  addr_sel  = 1'b1;
                  mem_wr_en = 1'b1;
                  pc_en     = w_mem_ready;
                  if (!w_mem_ready) w_state_next = StExec;
                end
                ExtJcond: begin
                  pc_en  = 1'b1;
                  pc_sel = w_take ? PcSelReg : PcSelInc;
                end
                ExtJal: begin
                  rf_wr_en = 1'b1;
                  wb_sel   = WbSelLink;
                  pc_sel   = PcSelReg;
                  pc_en    = 1'b1;
                end
                default: pc_en = 1'b1;
              endcase
            end
            default: pc_en = 1'b1;
          endcase
        end
      end

      StWb: begin
        rf_wr_en     = 1'b1;
        wb_sel       = WbSelMem;
        pc_en        = 1'b1;
        w_state_next = StFetch;
      end

      default: w_state_next = StFetch;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: per-cycle expectations queued by the stimulus,
// popped and compared by a negedge monitor.
module tb_ctrl_fsm;

  typedef struct packed {
    logic [1:0] st;
    logic       pc_en;
    logic       instr_en;
    logic       cmp_f_en;
    logic       of_f_en;
    logic       z_f_en;
    logic       rf_wr_en;
    logic       mem_wr_en;
    logic       addr_sel;
    logic [1:0] pc_sel;
    logic [1:0] wb_sel;
    logic       imm_sel;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instr;
  logic [15:0] psr;
`ifdef CTRL_MEM_WAIT_EN
  logic        mem_ready;
`endif
  logic        pc_en, instr_en, cmp_f_en, of_f_en, z_f_en;
  logic        rf_wr_en, mem_wr_en, addr_sel, imm_sel;
  logic [1:0]  pc_sel, wb_sel, state;

  exp_t  act;
  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  mon_e;
  string mon_t;
  int    checks = 0;
  int    errors = 0;
  bit    sim_done = 1'b0;

  ctrl_fsm dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .instr     (instr),
    .psr       (psr),
`ifdef CTRL_MEM_WAIT_EN
    .mem_ready (mem_ready),
`endif
    .pc_en     (pc_en),
    .instr_en  (instr_en),
    .cmp_f_en  (cmp_f_en),
    .of_f_en   (of_f_en),
    .z_f_en    (z_f_en),
    .rf_wr_en  (rf_wr_en),
    .mem_wr_en (mem_wr_en),
    .addr_sel  (addr_sel),
    .pc_sel    (pc_sel),
    .wb_sel    (wb_sel),
    .imm_sel   (imm_sel),
    .state     (state)
  );

  assign act = {state, pc_en, instr_en, cmp_f_en, of_f_en, z_f_en, rf_wr_en, mem_wr_en,
                addr_sel, pc_sel, wb_sel, imm_sel};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      checks++;
      if (act !== mon_e) begin
        errors++;
        $display("FAIL %s: outputs got %h expected %h (t=%0t)", mon_t, act, mon_e, $time);
      end
    end
  end

  initial begin
    #2000000;
    if (!sim_done) begin
      errors++;
      $display("FAIL timeout: simulation did not finish (t=%0t)", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  // Odd condition codes are the complement of the preceding even one.
  function automatic logic model_take(logic [3:0] cond, logic [15:0] p);
    logic [7:0] base;
    base = {1'b1, ~p[7] & ~p[6], ~p[2] & ~p[6], p[5], p[7], p[2], p[0], p[6]};
    return base[cond[3:1]] ^ cond[0];
  endfunction

  function automatic exp_t model_exec(logic [15:0] ins, logic [15:0] p, bit rdy);
    exp_t        e;
    int          op, ext;
    logic        take;
    logic [15:0] imm_ops;
    op      = int'(ins[15:12]);
    ext     = int'(ins[7:4]);
    take    = model_take(ins[11:8], p);
    imm_ops = 16'hAA2E;
    e       = '0;
    e.st    = 2'd2;
    if (op == 0 || imm_ops[op]) begin
      e.pc_en   = 1'b1;
      e.imm_sel = (op != 0);
      if ((op == 0 && ext == 11) || op == 11) begin
        e.cmp_f_en = 1'b1;
        e.z_f_en   = 1'b1;
      end else begin
        e.rf_wr_en = 1'b1;
      end
      e.of_f_en = (op == 0 && (ext == 5 || ext == 6 || ext == 7 || ext == 9)) ||
                  op == 5 || op == 9;
    end else if (op == 8) begin
      e.rf_wr_en = 1'b1;
      e.pc_en    = 1'b1;
    end else if (op == 12) begin
      e.pc_en  = 1'b1;
      e.pc_sel = take ? 2'd1 : 2'd0;
    end else if (op == 4) begin
      case (ext)
        0: e.addr_sel = 1'b1;
        4: begin
          e.addr_sel  = 1'b1;
          e.mem_wr_en = 1'b1;
          e.pc_en     = rdy;
        end
        8: begin
          e.rf_wr_en = 1'b1;
          e.wb_sel   = 2'd2;
          e.pc_sel   = 2'd2;
          e.pc_en    = 1'b1;
        end
        12: begin
          e.pc_en  = 1'b1;
          e.pc_sel = take ? 2'd2 : 2'd0;
        end
        default: e.pc_en = 1'b1;
      endcase
    end else begin
      e.pc_en = 1'b1;
    end
    return e;
  endfunction

  task automatic push(input exp_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic [15:0] p, input string tag);
    exp_t e;
    bit   rdy_q[$];
    int   fw, ew;
    bit   is_ld, is_st;
    is_ld = (ins[15:12] == 4'd4) && (ins[7:4] == 4'd0);
    is_st = (ins[15:12] == 4'd4) && (ins[7:4] == 4'd4);
    fw = 0;
    ew = 0;
`ifdef CTRL_MEM_WAIT_EN
    fw = $urandom_range(0, 2);
    if (is_ld || is_st) ew = $urandom_range(0, 2);
`endif
    instr = ins;
    psr   = p;
    for (int i = 0; i <= fw; i++) begin
      push('0, {tag, "/fetch"});
      rdy_q.push_back(i == fw);
    end
    e = '0;
    e.st = 2'd1;
    e.instr_en = 1'b1;
    push(e, {tag, "/latch"});
    rdy_q.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < ew; i++) begin
      push(model_exec(ins, p, 1'b0), {tag, "/exec_wait"});
      rdy_q.push_back(1'b0);
    end
    push(model_exec(ins, p, 1'b1), {tag, "/exec"});
    rdy_q.push_back(1'b1);
    if (is_ld) begin
      e = '0;
      e.st = 2'd3;
      e.rf_wr_en = 1'b1;
      e.wb_sel = 2'd1;
      e.pc_en = 1'b1;
      push(e, {tag, "/wb"});
      rdy_q.push_back(1'($urandom_range(0, 1)));
    end
    foreach (rdy_q[i]) begin
`ifdef CTRL_MEM_WAIT_EN
      mem_ready = rdy_q[i];
`endif
      @(posedge clk);
      #1;
    end
  endtask

  // Reset pulled in the EXEC cycle of an ADD: outputs must drop to zero at once.
  task automatic run_reset_mid();
    exp_t e;
    instr = 16'h0152;
    psr   = 16'h0000;
`ifdef CTRL_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    push('0, "rst_mid/fetch");
    e = '0;
    e.st = 2'd1;
    e.instr_en = 1'b1;
    push(e, "rst_mid/latch");
    push('0, "rst_mid/exec_in_reset");
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] ins;
    reset_n = 1'b0;
    instr   = 16'h0000;
    psr     = 16'h0000;
`ifdef CTRL_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    for (int i = 0; i < 3; i++) push('0, "reset");
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs got %h expected 0 (t=%0t)", act, $time);
    end
    reset_n = 1'b1;

    run_instr(16'h0152, 16'h0000, "add");
    run_instr(16'hB105, 16'h0000, "cmpi");
    run_instr(16'hC0FE, 16'h0040, "beq_taken");
    run_instr(16'hC0FE, 16'h0000, "beq_not");
    run_instr(16'h4102, 16'h0000, "load");
    run_instr(16'h4143, 16'h0000, "stor");
    run_instr(16'h4381, 16'h0000, "jal");
    run_instr(16'h4EC3, 16'h0000, "juc");
    run_instr(16'h4FC3, 16'hFFFF, "jnever");
    run_instr(16'h8105, 16'h0000, "shift");
    run_instr(16'h6000, 16'h0000, "nop_op");
    run_instr(16'h4020, 16'h0000, "nop_ext");
    run_instr(16'h01B2, 16'h0000, "cmp_r");
    run_instr(16'h1234, 16'h0000, "andi");

    for (int n = 0; n < 300; n++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        ins[15:12] = 4'd4;
        ins[7:4]   = 4'($urandom_range(0, 3) * 4);
      end
      if (n == 150) run_reset_mid();
      run_instr(ins, 16'($urandom), "rand");
    end

    repeat (2) @(posedge clk);
    sim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
# ctrl_fsm

Multi-cycle control state machine for the CR16-subset datapath. It sequences each instruction through fetch, instruction latch, execute and (for loads) writeback. It drives the enable and select inputs of the processor register block (PC, instruction register, PSR flag groups), the register file and data memory. It sits directly upstream of the processor register block: it consumes that block's `instr` and `psr` outputs and produces its `pc_en`, `instr_en`, `cmp_f_en`, `of_f_en` and `z_f_en` inputs.

## Interface
- No parameters.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instr`  in  16  latched instruction from the processor register block.
- `psr`  in  16  flags: C=bit0, L=bit2, F=bit5, Z=bit6, N=bit7.
- `mem_ready`  in  1  memory handshake; present only with `CTRL_MEM_WAIT_EN`.
- `pc_en`, `instr_en`  out  1  load PC and instruction register.
- `cmp_f_en`, `of_f_en`, `z_f_en`  out  1  PSR flag-group write enables.
- `rf_wr_en`  out  1  register-file write.
- `mem_wr_en`  out  1  data-memory write.
- `addr_sel`  out  1  memory address source: 0 = PC, 1 = Rsrc.
- `pc_sel`  out  2  next PC: 00 = PC+1, 01 = PC+sign-extended disp8, 10 = Rtarget.
- `wb_sel`  out  2  writeback source: 00 = ALU, 01 = memory, 10 = PC+1 (link).
- `imm_sel`  out  1  ALU B operand is the immediate.
- `state`  out  2  current state, for debug.

## Operation
- Decode fields: op = `instr[15:12]`, ext = `instr[7:4]`, cond = `instr[11:8]`.
- States: FETCH=0, LATCH=1, EXEC=2, WB=3.
- State transitions:
  - FETCH -> LATCH.
  - LATCH -> EXEC.
  - EXEC -> WB for LOAD; EXEC -> FETCH for every other instruction.
  - WB -> FETCH.
- FETCH: all outputs 0 (`addr_sel`=0, so memory reads at PC).
- LATCH: `instr_en`=1; all other outputs 0.
- EXEC, R-type (op 0000) and immediates (op 0001/0010/0011/0101/1001/1011/1101/1111):
  - `rf_wr_en`=1, `pc_en`=1, `pc_sel`=00.
  - `imm_sel`=1 when op≠0000.
  - CMP/CMPI (ext or op 1011): `rf_wr_en`=0, `cmp_f_en`=1, `z_f_en`=1.
  - ADD/ADDU/ADDC/SUB/ADDI/SUBI: `of_f_en`=1.
- EXEC, shifts (op 1000): `rf_wr_en`=1, `pc_en`=1; no flag enables.
- EXEC, LOAD (op 0100, ext 0000): `addr_sel`=1; no enables.
- WB (LOAD only): `rf_wr_en`=1, `wb_sel`=01, `pc_en`=1.
- EXEC, STOR (op 0100, ext 0100): `addr_sel`=1, `mem_wr_en`=1, `pc_en`=1.
- EXEC, Bcond (op 1100): `pc_en`=1; `pc_sel`=01 if cond true, else 00.
- EXEC, Jcond (op 0100, ext 1100): `pc_en`=1; `pc_sel`=10 if cond true, else 00.
- EXEC, JAL (op 0100, ext 1000): `rf_wr_en`=1, `wb_sel`=10, `pc_sel`=10, `pc_en`=1.
- Condition evaluation:
  - EQ 0000: Z.
  - NE 0001: !Z.
  - CS 0010: C.
  - CC 0011: !C.
  - HI 0100: L.
  - LS 0101: !L.
  - GT 0110: N.
  - LE 0111: !N.
  - FS 1000: F.
  - FC 1001: !F.
  - LO 1010: !L&!Z.
  - HS 1011: L|Z.
  - LT 1100: !N&!Z.
  - GE 1101: N|Z.
  - UC 1110: 1.
  - 1111: 0.
- Undefined opcode/ext combinations execute as a NOP: EXEC asserts only `pc_en` with `pc_sel`=00.
- Exactly one `pc_en` pulse per instruction; `instr_en` pulses exactly once per instruction.

## Timing
- Outputs are combinational from `state` plus `instr`; no registered outputs.
- While `reset_n`=0: state=FETCH and all outputs 0. The first FETCH follows the first rising edge after `reset_n` is released.
- Reset asserted mid-instruction forces FETCH immediately. No partial writes may occur after assertion.
- Latency: ALU, store, branch, jump and NOP take 3 cycles; LOAD takes 4 cycles.
- Flags written in EXEC are visible in `psr` from the next FETCH onward, so a branch that immediately follows a CMP sees the updated flags.

## Configuration
- `CTRL_MEM_WAIT_EN` defined:
  - `mem_ready` port exists.
  - FETCH holds until `mem_ready`=1.
  - LOAD EXEC holds with `addr_sel`=1 until `mem_ready`=1.
  - STOR EXEC holds `mem_wr_en`=1 and asserts `pc_en` only in the cycle where `mem_ready`=1.
- Undefined: no `mem_ready` port; memory is fixed at 1-cycle synchronous latency.

## Structure
- Shared package `ctrl_pkg`:
  - state encodings;
  - op/ext constants;
  - condition-code constants;
  - `pc_sel`/`wb_sel` encodings;
  - PSR bit indices C=0, L=2, F=5, Z=6, N=7 (shared with the register block).
- Sub-module `cond_eval` (combinational): inputs cond[3:0] and psr; output `take`.

## Test plan
- Reset: hold `reset_n`=0 for 3 cycles -> all outputs 0 and `state`=0. After release, `state` sequences 0,1,2.
- ADD r1,r2 (instr 0x0152) -> LATCH `instr_en`=1; EXEC `rf_wr_en`=1, `of_f_en`=1, `pc_en`=1, `pc_sel`=00, `cmp_f_en`=0.
- CMPI (instr 0xB105) -> EXEC `cmp_f_en`=1, `z_f_en`=1, `imm_sel`=1, `rf_wr_en`=0.
- BEQ (instr 0xC0FE):
  - with psr=0x0040 -> EXEC `pc_sel`=01;
  - with psr=0x0000 -> `pc_sel`=00;
  - `pc_en`=1 in both cases.
- LOAD (instr 0x4102) -> EXEC `addr_sel`=1, `pc_en`=0; WB `rf_wr_en`=1, `wb_sel`=01, `pc_en`=1. Total 4 cycles.
- With `CTRL_MEM_WAIT_EN`, `mem_ready` low for 2 cycles during FETCH -> `state` holds at 0 for those 2 cycles, then advances to 1.
